// File: rtl/return_address_stack.sv
// Circular return-address stack: pushes call return addresses, predicts the
// target of returns, and tracks occupancy with one-cycle overflow/underflow flags.
module return_address_stack #(
    parameter  int DEPTH  = 8,
    parameter  int ADDR_W = 32,
    localparam int PTR_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] push_addr,
    output logic [ADDR_W-1:0] top_addr,
    output logic              top_valid,
    output logic [PTR_W:0]    count,
    output logic              overflow,
    output logic              underflow
);

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [ADDR_W-1:0] mem [DEPTH];

    logic [PTR_W-1:0] tos_reg, tos_next;
    logic [PTR_W:0]   cnt_reg, cnt_next;
    logic             overflow_reg, overflow_next;
    logic             underflow_reg, underflow_next;
    logic             mem_we;
    logic [PTR_W-1:0] mem_waddr;

    logic active;
    logic empty;
    logic swap;

    assign active = !flush && !stall;
    assign empty  = (cnt_reg == '0);
    // Simultaneous push+pop on a non-empty stack replaces the top in place;
    // on an empty stack it degenerates to a plain push.
    assign swap   = push && pop && !empty;

    always_comb begin
        tos_next       = tos_reg;
        cnt_next       = cnt_reg;
        overflow_next  = 1'b0;
        underflow_next = 1'b0;
        mem_we         = 1'b0;
        mem_waddr      = tos_reg + PTR_W'(1);

        if (flush) begin
            tos_next = '0;
            cnt_next = '0;
        end else if (active) begin
            if (swap) begin
                mem_we    = 1'b1;
                mem_waddr = tos_reg;
            end else if (push) begin
                mem_we   = 1'b1;
                tos_next = tos_reg + PTR_W'(1);
                if (cnt_reg == FULL_CNT) begin
                    overflow_next = 1'b1;
                end else begin
                    cnt_next = cnt_reg + (PTR_W + 1)'(1);
                end
            end else if (pop) begin
                if (empty) begin
                    underflow_next = 1'b1;
                end else begin
                    tos_next = tos_reg - PTR_W'(1);
                    cnt_next = cnt_reg - (PTR_W + 1)'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tos_reg       <= '0;
            cnt_reg       <= '0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            tos_reg       <= tos_next;
            cnt_reg       <= cnt_next;
            overflow_reg  <= overflow_next;
            underflow_reg <= underflow_next;
        end
    end

    // Storage carries no reset; validity is tracked solely by cnt_reg.
    always_ff @(posedge clk) begin
        if (!rst && mem_we) begin
            mem[mem_waddr] <= push_addr;
        end
    end

    assign top_valid = !empty;
    assign top_addr  = top_valid ? mem[tos_reg] : '0;
    assign count     = cnt_reg;
    assign overflow  = overflow_reg;
    assign underflow = underflow_reg;

endmodule

// File: tb/tb_return_address_stack.sv
// Bench for return_address_stack (DEPTH=4): directed vector table followed by
// random traffic checked against a queue-based model of the stack.
module tb_return_address_stack;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = 32;

    logic              clk = 1'b0;
    logic              rst, flush, stall, push, pop;
    logic [ADDR_W-1:0] push_addr;
    logic [ADDR_W-1:0] top_addr;
    logic              top_valid;
    logic [2:0]        count;
    logic              overflow, underflow;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    return_address_stack #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .push(push), .pop(pop), .push_addr(push_addr),
        .top_addr(top_addr), .top_valid(top_valid), .count(count),
        .overflow(overflow), .underflow(underflow)
    );

    // Reference: queue with oldest entry at the front, newest at the back.
    logic [ADDR_W-1:0] q[$];
    logic              m_ovf, m_unf;

    task automatic model_step(input logic r, f, s, pu, po, input logic [ADDR_W-1:0] a);
        m_ovf = 1'b0;
        m_unf = 1'b0;
        if (r || f) begin
            q.delete();
        end else if (!s) begin
            if (pu && po && q.size() > 0) begin
                q[q.size()-1] = a;
            end else if (pu) begin
                q.push_back(a);
                if (q.size() > DEPTH) begin
                    void'(q.pop_front());
                    m_ovf = 1'b1;
                end
            end else if (po) begin
                if (q.size() > 0) void'(q.pop_back());
                else m_unf = 1'b1;
            end
        end
    endtask

    task automatic drive(input logic r, f, s, pu, po, input logic [ADDR_W-1:0] a);
        @(negedge clk);
        rst = r; flush = f; stall = s; push = pu; pop = po; push_addr = a;
        @(posedge clk);
        #1;
        model_step(r, f, s, pu, po, a);
    endtask

    task automatic check(input string tag, input string name,
                         input logic [ADDR_W-1:0] act, input logic [ADDR_W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s %s: got %h expected %h", tag, name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input int e_cnt, input logic [ADDR_W-1:0] e_top,
                             input logic e_valid, input logic e_ovf, input logic e_unf);
        $display("%s: rst=%b fl=%b st=%b push=%b pop=%b addr=%h -> cnt=%0d top=%h v=%b ov=%b un=%b",
                 tag, rst, flush, stall, push, pop, push_addr,
                 count, top_addr, top_valid, overflow, underflow);
        check(tag, "count",     32'(count),     32'(e_cnt));
        check(tag, "top_addr",  top_addr,       e_top);
        check(tag, "top_valid", 32'(top_valid), 32'(e_valid));
        check(tag, "overflow",  32'(overflow),  32'(e_ovf));
        check(tag, "underflow", 32'(underflow), 32'(e_unf));
    endtask

    typedef struct {
        logic              r, f, s, pu, po;
        logic [ADDR_W-1:0] addr;
        int                cnt;
        logic [ADDR_W-1:0] top;
        logic              valid, ovf, unf;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, f, s, pu, po, input logic [ADDR_W-1:0] addr,
                       input int cnt, input logic [ADDR_W-1:0] top,
                       input logic valid, ovf, unf);
        vec_t v;
        v.r = r; v.f = f; v.s = s; v.pu = pu; v.po = po; v.addr = addr;
        v.cnt = cnt; v.top = top; v.valid = valid; v.ovf = ovf; v.unf = unf;
        vecs.push_back(v);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; stall = 1'b0; push = 1'b0; pop = 1'b0; push_addr = '0;

        //   rst fl st pu po addr        cnt top        v  ov un
        add(1, 0, 0, 0, 0, 32'h0,      0, 32'h0,    0, 0, 0);
        add(0, 0, 0, 0, 0, 32'h0,      0, 32'h0,    0, 0, 0);
        add(0, 0, 0, 1, 0, 32'h100,    1, 32'h100,  1, 0, 0);
        add(0, 0, 0, 1, 0, 32'h200,    2, 32'h200,  1, 0, 0);
        add(0, 0, 0, 1, 0, 32'h300,    3, 32'h300,  1, 0, 0);
        add(0, 0, 0, 0, 1, 32'h0,      2, 32'h200,  1, 0, 0);
        add(0, 0, 0, 0, 1, 32'h0,      1, 32'h100,  1, 0, 0);
        add(0, 0, 0, 0, 1, 32'h0,      0, 32'h0,    0, 0, 0);
        add(0, 0, 0, 1, 0, 32'h10,     1, 32'h10,   1, 0, 0);
        add(0, 0, 0, 1, 0, 32'h20,     2, 32'h20,   1, 0, 0);
        add(0, 0, 0, 1, 0, 32'h30,     3, 32'h30,   1, 0, 0);
        add(0, 0, 0, 1, 0, 32'h40,     4, 32'h40,   1, 0, 0);
        add(0, 0, 0, 1, 0, 32'h50,     4, 32'h50,   1, 1, 0);
        add(0, 0, 0, 0, 0, 32'h0,      4, 32'h50,   1, 0, 0);
        add(0, 0, 0, 0, 1, 32'h0,      3, 32'h40,   1, 0, 0);
        add(0, 0, 0, 0, 1, 32'h0,      2, 32'h30,   1, 0, 0);
        add(0, 0, 0, 0, 1, 32'h0,      1, 32'h20,   1, 0, 0);
        add(0, 0, 0, 0, 1, 32'h0,      0, 32'h0,    0, 0, 0);
        add(0, 0, 0, 0, 1, 32'h0,      0, 32'h0,    0, 0, 1);
        add(0, 0, 0, 0, 0, 32'h0,      0, 32'h0,    0, 0, 0);
        add(0, 0, 0, 1, 1, 32'h44,     1, 32'h44,   1, 0, 0);
        add(0, 0, 0, 0, 1, 32'h0,      0, 32'h0,    0, 0, 0);
        add(0, 0, 0, 1, 0, 32'hA0,     1, 32'hA0,   1, 0, 0);
        add(0, 0, 0, 1, 0, 32'hB0,     2, 32'hB0,   1, 0, 0);
        add(0, 0, 0, 1, 1, 32'hC0,     2, 32'hC0,   1, 0, 0);
        add(0, 0, 0, 0, 1, 32'h0,      1, 32'hA0,   1, 0, 0);
        add(0, 0, 0, 1, 0, 32'hB1,     2, 32'hB1,   1, 0, 0);
        add(0, 0, 1, 1, 0, 32'h77,     2, 32'hB1,   1, 0, 0);
        add(0, 0, 1, 0, 1, 32'h0,      2, 32'hB1,   1, 0, 0);
        add(0, 1, 0, 1, 0, 32'h88,     0, 32'h0,    0, 0, 0);
        add(0, 0, 0, 0, 1, 32'h0,      0, 32'h0,    0, 0, 1);
        add(0, 0, 1, 0, 1, 32'h0,      0, 32'h0,    0, 0, 0);
        add(0, 0, 0, 1, 0, 32'h99,     1, 32'h99,   1, 0, 0);
        add(1, 0, 0, 1, 0, 32'h55,     0, 32'h0,    0, 0, 0);

        foreach (vecs[i]) begin
            drive(vecs[i].r, vecs[i].f, vecs[i].s, vecs[i].pu, vecs[i].po, vecs[i].addr);
            check_all($sformatf("vec%0d", i), vecs[i].cnt, vecs[i].top,
                      vecs[i].valid, vecs[i].ovf, vecs[i].unf);
        end

        // Overflow pulse must be cleared by a following stall cycle.
        for (int i = 0; i < 5; i++) drive(0, 0, 0, 1, 0, 32'h1000 + 32'(i));
        check_all("ovf_pulse", 4, 32'h1004, 1, 1, 0);
        drive(0, 0, 1, 1, 0, 32'hDEAD);
        check_all("ovf_stall", 4, 32'h1004, 1, 0, 0);

        // Random traffic against the queue model.
        drive(1, 0, 0, 0, 0, 32'h0);
        for (int n = 0; n < 400; n++) begin
            logic r, f, s, pu, po;
            logic [ADDR_W-1:0] a;
            r  = ($urandom_range(63) == 0);
            f  = ($urandom_range(31) == 0);
            s  = ($urandom_range(7) == 0);
            pu = $urandom_range(1);
            po = $urandom_range(1);
            a  = $urandom;
            drive(r, f, s, pu, po, a);
            check_all($sformatf("rnd%0d", n), q.size(),
                      (q.size() > 0) ? q[q.size()-1] : '0,
                      q.size() > 0, m_ovf, m_unf);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
